// File: rtl/snake_if.sv
// snake_if: button pulses in, frame bitmap and status out.
// N is the cell count of the board (img width).
interface snake_if #(
  parameter int N = 36
);
  logic         btn_up;
  logic         btn_left;
  logic         btn_right;
  logic         btn_down;
  logic [N-1:0] img;
  logic         game_over;
  logic [4:0]   length;
  logic         step;

  modport master (
    output btn_up, btn_left, btn_right, btn_down,
    input  img, game_over, length, step
  );

  modport slave (
    input  btn_up, btn_left, btn_right, btn_down,
    output img, game_over, length, step
  );
endinterface

// File: rtl/snake_engine.sv
// snake_engine: snake game core for a small LED matrix.
// Define WRAP_EN to make wall exits wrap to the opposite edge.
module snake_engine #(
  parameter int          DIM_X     = 6,
  parameter int          DIM_Y     = 6,
  parameter int          MAX_LEN   = 16,
  parameter int          TICK_DIV  = 6000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic   clk,
  input  logic   rst_n,
  snake_if.slave bus
);
  localparam int N  = DIM_X * DIM_Y;
  localparam int IW = $clog2(N);
  localparam int XW = $clog2(DIM_X);
  localparam int YW = $clog2(DIM_Y);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int LW = 5;

  localparam logic [IW-1:0] FOOD0 = IW'(3 * DIM_X + 4);
  localparam logic [N-1:0]  BODY0 = N'(7);

  typedef enum logic [2:0] {
    S_RUN, S_MOVE, S_COMMIT, S_PLACE, S_OVER
  } state_t;

  // Opposite directions are bitwise complements.
  typedef enum logic [1:0] {
    D_UP    = 2'b00,
    D_LEFT  = 2'b01,
    D_RIGHT = 2'b10,
    D_DOWN  = 2'b11
  } dir_t;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  dir_t          ndir_q, ndir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic [XW-1:0] hx_q, hx_d, nx_q, nx_d;
  logic [YW-1:0] hy_q, hy_d, ny_q, ny_d;
  logic [PW-1:0] hptr_q, hptr_d;
  logic [PW-1:0] tptr_q, tptr_d;
  logic [N-1:0]  bmp_q, bmp_d;
  logic [N-1:0]  img_q, img_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] food_q, food_d;
  logic [IW-1:0] nidx_q, nidx_d;
  logic          eat_q, eat_d;
  logic          hit_q, hit_d;
  logic [7:0]    lfsr_q;
  logic [IW-1:0] buf_q [MAX_LEN];

  logic          push, init;
  dir_t          bsel;
  logic          bsel_v, any_btn;
  logic [XW-1:0] mx;
  logic [YW-1:0] my;
  logic [IW-1:0] midx, tail_idx, cand;
  logic          oob, hit_m, eat_m, coll;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign any_btn = bus.btn_up | bus.btn_left
                 | bus.btn_right | bus.btn_down;

  // Pick one button per cycle: up > left > right > down.
  always_comb begin
    bsel   = D_UP;
    bsel_v = 1'b1;
    priority case (1'b1)
      bus.btn_up:    bsel = D_UP;
      bus.btn_left:  bsel = D_LEFT;
      bus.btn_right: bsel = D_RIGHT;
      bus.btn_down:  bsel = D_DOWN;
      default:       bsel_v = 1'b0;
    endcase
  end

  // Candidate head cell, wall exit and collision test.
  always_comb begin
    mx  = hx_q;
    my  = hy_q;
    oob = 1'b0;
    unique case (dir_q)
      D_UP: begin
        if (hy_q == YW'(DIM_Y - 1)) begin
`ifdef WRAP_EN
          my = '0;
`else
          oob = 1'b1;
`endif
        end else my = hy_q + 1'b1;
      end
      D_DOWN: begin
        if (hy_q == '0) begin
`ifdef WRAP_EN
          my = YW'(DIM_Y - 1);
`else
          oob = 1'b1;
`endif
        end else my = hy_q - 1'b1;
      end
      D_LEFT: begin
        if (hx_q == '0) begin
`ifdef WRAP_EN
          mx = XW'(DIM_X - 1);
`else
          oob = 1'b1;
`endif
        end else mx = hx_q - 1'b1;
      end
      D_RIGHT: begin
        if (hx_q == XW'(DIM_X - 1)) begin
`ifdef WRAP_EN
          mx = '0;
`else
          oob = 1'b1;
`endif
        end else mx = hx_q + 1'b1;
      end
      default: ;
    endcase
    midx     = IW'(my) * IW'(DIM_X) + IW'(mx);
    tail_idx = buf_q[tptr_q];
    hit_m    = (midx == food_q);
    eat_m    = hit_m && (len_q < LW'(MAX_LEN));
    // The tail cell is vacated this move unless we grow.
    coll     = bmp_q[midx]
             && !((midx == tail_idx) && !eat_m);
    cand     = IW'(lfsr_q % 8'(N));
  end

  // Next-state logic for the game FSM and snake state.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ndir_d  = ndir_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    hx_d    = hx_q;
    hy_d    = hy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nidx_d  = nidx_q;
    eat_d   = eat_q;
    hit_d   = hit_q;
    hptr_d  = hptr_q;
    tptr_d  = tptr_q;
    bmp_d   = bmp_q;
    len_d   = len_q;
    food_d  = food_q;
    push    = 1'b0;
    init    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (bsel_v && (bsel != ~dir_q)) ndir_d = bsel;
        if (cnt_q == CW'(TICK_DIV - 1)) begin
          cnt_d   = '0;
          step_d  = 1'b1;
          dir_d   = ndir_d;
          state_d = S_MOVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MOVE: begin
        nx_d   = mx;
        ny_d   = my;
        nidx_d = midx;
        hit_d  = hit_m;
        eat_d  = eat_m;
        if (oob || coll) state_d = S_OVER;
        else             state_d = S_COMMIT;
      end
      S_COMMIT: begin
        push   = 1'b1;
        hptr_d = inc(hptr_q);
        hx_d   = nx_q;
        hy_d   = ny_q;
        if (eat_q) begin
          len_d = len_q + 1'b1;
        end else begin
          bmp_d[tail_idx] = 1'b0;
          tptr_d          = inc(tptr_q);
        end
        bmp_d[nidx_q] = 1'b1;
        state_d = hit_q ? S_PLACE : S_RUN;
      end
      S_PLACE: begin
        if (!bmp_q[cand]) begin
          food_d  = cand;
          state_d = S_RUN;
        end
      end
      S_OVER: begin
        if (any_btn) init = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
    if (init) begin
      state_d = S_RUN;
      dir_d   = D_RIGHT;
      ndir_d  = D_RIGHT;
      cnt_d   = '0;
      hx_d    = XW'(2);
      hy_d    = '0;
      hptr_d  = PW'(2);
      tptr_d  = '0;
      bmp_d   = BODY0;
      len_d   = LW'(3);
      food_d  = FOOD0;
    end
    img_d = bmp_d
          | ((state_d == S_PLACE) ? '0 : (N'(1) << food_d));
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      dir_q   <= D_RIGHT;
      ndir_q  <= D_RIGHT;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      hx_q    <= XW'(2);
      hy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      nidx_q  <= '0;
      eat_q   <= 1'b0;
      hit_q   <= 1'b0;
      hptr_q  <= PW'(2);
      tptr_q  <= '0;
      bmp_q   <= BODY0;
      img_q   <= BODY0 | (N'(1) << FOOD0);
      len_q   <= LW'(3);
      food_q  <= FOOD0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ndir_q  <= ndir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      nidx_q  <= nidx_d;
      eat_q   <= eat_d;
      hit_q   <= hit_d;
      hptr_q  <= hptr_d;
      tptr_q  <= tptr_d;
      bmp_q   <= bmp_d;
      img_q   <= img_d;
      len_q   <= len_d;
      food_q  <= food_d;
    end
  end

  // Body cell ring buffer; head slot written on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++)
        buf_q[i] <= (i < 3) ? IW'(i) : '0;
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++)
        buf_q[i] <= (i < 3) ? IW'(i) : '0;
    end else if (push) begin
      buf_q[hptr_d] <= nidx_q;
    end
  end

  // Food LFSR, x^8+x^6+x^5+x^4+1, free running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (init) lfsr_q <= LFSR_SEED;
    else lfsr_q <= {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5]
                    ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign bus.img       = img_q;
  assign bus.game_over = (state_q == S_OVER);
  assign bus.length    = len_q;
  assign bus.step      = step_q;
endmodule
